// File: rtl/ex_muldiv_pkg.sv
// Shared M-extension definitions: funct3 op encodings, FSM state type, operand-sign helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // rs1 is read as two's complement for these ops
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is read as two's complement for these ops
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Execute-stage <-> multiply/divide unit request and response bundle.
// Latency: n/a (wires only).
// Backpressure: MD_Busy stalls the pipeline while the unit accepts or iterates.
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  E_Start;
    logic [2:0]            E_Funct3;
    logic [DATA_WIDTH-1:0] E_SrcA;
    logic [DATA_WIDTH-1:0] E_SrcB;
    logic [4:0]            E_Rd;
    logic                  E_Flush;
    logic                  MD_Busy;
    logic                  MD_Done;
    logic [DATA_WIDTH-1:0] MD_Result;
    logic [4:0]            MD_Rd;

    // Pipeline side: issues requests, consumes results
    modport master (
        output E_Start, E_Funct3, E_SrcA, E_SrcB, E_Rd, E_Flush,
        input  MD_Busy, MD_Done, MD_Result, MD_Rd
    );

    // Unit side
    modport slave (
        input  E_Start, E_Funct3, E_SrcA, E_SrcB, E_Rd, E_Flush,
        output MD_Busy, MD_Done, MD_Result, MD_Rd
    );
endinterface

// File: rtl/ex_muldiv_core.sv
// Radix-2 iterative unsigned datapath: shift-add multiply or restoring shift-subtract divide.
// Latency: one step per step_i cycle; last_o flags the DATA_WIDTH-th step.
// Backpressure: none; the controlling FSM decides when to load and step.
module ex_muldiv_core #(
    parameter int DATA_WIDTH = 32,
    parameter int XLEN_LOG2  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] op_i,      // multiplicand or divisor magnitude
    input  logic [DATA_WIDTH-1:0] sreg_i,    // multiplier or dividend magnitude
    output logic [DATA_WIDTH-1:0] acc_d_o,   // accumulator after the current step
    output logic [DATA_WIDTH-1:0] sreg_d_o,  // shift register after the current step
    output logic                  last_o
);
    localparam int DW = DATA_WIDTH;
    localparam logic [XLEN_LOG2-1:0] CNT_LAST = XLEN_LOG2'(DW - 1);

    logic [DW-1:0]        acc_q, sreg_q, op_q;
    logic [XLEN_LOG2-1:0] cnt_q;
    logic                 div_q;

    logic [DW:0]   mul_sum;
    logic [DW:0]   div_shift;
    logic          div_fits;
    logic [DW-1:0] div_sub;
    logic [DW-1:0] acc_d, sreg_d;

    // One iteration: multiply shifts {acc,sreg} right after a conditional add,
    // divide shifts the remainder left and subtracts when the divisor fits.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, op_q} : '0);
        div_shift = {acc_q, sreg_q[DW-1]};
        div_fits  = (div_shift >= {1'b0, op_q});
        div_sub   = div_shift[DW-1:0] - op_q;
        if (div_q) begin
            acc_d  = div_fits ? div_sub : div_shift[DW-1:0];
            sreg_d = {sreg_q[DW-2:0], div_fits};
        end else begin
            acc_d  = mul_sum[DW:1];
            sreg_d = {mul_sum[0], sreg_q[DW-1:1]};
        end
    end

    assign acc_d_o  = acc_d;
    assign sreg_d_o = sreg_d;
    assign last_o   = (cnt_q == CNT_LAST);

    // Operand load on accept, then one step per cycle while stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            sreg_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else if (load_i) begin
            acc_q  <= '0;
            sreg_q <= sreg_i;
            op_q   <= op_i;
            cnt_q  <= '0;
            div_q  <= is_div_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q + XLEN_LOG2'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: sign handling, div special cases, IDLE/CALC/DONE control.
// Latency: DATA_WIDTH+1 cycles from request to MD_Done; 1 cycle for div-by-zero / overflow.
// Backpressure: MD_Busy stalls the pipeline from request until the DONE cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int XLEN_LOG2  = 5
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave md
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    md_state_e     state_q;
    logic [2:0]    f3_q;
    logic          neg_q;       // final result must be negated
    logic [4:0]    rd_q;
    logic [DW-1:0] result_q;
    logic [4:0]    md_rd_q;
    logic          done_q;

    logic          accept;
    logic          a_neg, b_neg, req_div, div_zero, div_ovf, special, res_neg;
    logic [DW-1:0] a_mag, b_mag, special_res, ld_op, ld_sreg;

    logic          core_load, core_step, core_last;
    logic [DW-1:0] core_acc_d, core_sreg_d;

    logic [2*DW-1:0] prod_mag, prod_fix;
    logic [DW-1:0]   div_mag, div_fix, calc_res;

    assign accept = (state_q == ST_IDLE) && md.E_Start && !md.E_Flush;

    // Request decode: operand magnitudes, result sign, and the two divide special cases
    always_comb begin
        req_div  = md.E_Funct3[2];
        a_neg    = f3_a_signed(md.E_Funct3) && md.E_SrcA[DW-1];
        b_neg    = f3_b_signed(md.E_Funct3) && md.E_SrcB[DW-1];
        a_mag    = a_neg ? -md.E_SrcA : md.E_SrcA;
        b_mag    = b_neg ? -md.E_SrcB : md.E_SrcB;
        // remainder follows the dividend; product and quotient follow the sign product
        res_neg  = (req_div && md.E_Funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = req_div && (md.E_SrcB == '0);
        div_ovf  = req_div && !md.E_Funct3[0] && (md.E_SrcA == MIN_NEG) && (md.E_SrcB == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = md.E_Funct3[1] ? md.E_SrcA : '1;
        end else begin
            special_res = md.E_Funct3[1] ? '0 : md.E_SrcA;
        end
        // multiply iterates over the multiplier, divide over the dividend
        ld_op   = req_div ? b_mag : a_mag;
        ld_sreg = req_div ? a_mag : b_mag;
    end

    assign core_load = accept && !special;
    assign core_step = (state_q == ST_CALC) && !md.E_Flush;

    ex_muldiv_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .XLEN_LOG2  (XLEN_LOG2)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (req_div),
        .op_i     (ld_op),
        .sreg_i   (ld_sreg),
        .acc_d_o  (core_acc_d),
        .sreg_d_o (core_sreg_d),
        .last_o   (core_last)
    );

    // Final result from the last iteration, sign-corrected and half-selected
    always_comb begin
        prod_mag = {core_acc_d, core_sreg_d};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        div_mag  = f3_q[1] ? core_acc_d : core_sreg_d;
        div_fix  = neg_q ? -div_mag : div_mag;
        if (f3_q[2]) begin
            calc_res = div_fix;
        end else if (f3_q[1:0] == 2'b00) begin
            calc_res = prod_fix[DW-1:0];
        end else begin
            calc_res = prod_fix[2*DW-1:DW];
        end
    end

    // Control FSM with registered done pulse, result and destination register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            md_rd_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q  <= md.E_Funct3;
                        neg_q <= res_neg;
                        rd_q  <= md.E_Rd;
                        if (special) begin
                            state_q  <= ST_DONE;
                            result_q <= special_res;
                            md_rd_q  <= md.E_Rd;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (md.E_Flush) begin
                        state_q <= ST_IDLE;
                    end else if (core_last) begin
                        state_q  <= ST_DONE;
                        result_q <= calc_res;
                        md_rd_q  <= rd_q;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall covers the request cycle and every iteration; released in DONE
    assign md.MD_Busy   = !rst && (accept || (state_q == ST_CALC));
    assign md.MD_Done   = done_q;
    assign md.MD_Result = result_q;
    assign md.MD_Rd     = md_rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, flush/reset cases, random ops vs model.
// Latency: checks 33-cycle normal and 1-cycle special-case completion.
// Backpressure: checks MD_Busy over request, iteration and done cycles.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_WIDTH(32)) mdif ();

    ex_muldiv #(
        .DATA_WIDTH (32),
        .XLEN_LOG2  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .md  (mdif)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural RV32M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        int ia, ib;
        longint sa, sb, ua, ub;
        logic [63:0] p;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, scramble the held request while iterating, check timing and result
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_bad;
        bit seen;
        @(negedge clk);
        mdif.E_Start  = 1'b1;
        mdif.E_Funct3 = f3;
        mdif.E_SrcA   = a;
        mdif.E_SrcB   = b;
        mdif.E_Rd     = rd;
        mdif.E_Flush  = 1'b0;
        #1 chk({tag, "_busy_req"}, mdif.MD_Busy, 1);
        lat = 0; busy_bad = 0; seen = 0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (mdif.MD_Done) begin
                seen = 1;
            end else begin
                if (!mdif.MD_Busy) busy_bad++;
                mdif.E_Start  = 1'($urandom_range(0, 1));
                mdif.E_Funct3 = 3'($urandom_range(0, 7));
                mdif.E_SrcA   = $urandom;
                mdif.E_SrcB   = $urandom;
                mdif.E_Rd     = 5'($urandom_range(0, 31));
            end
        end
        chk({tag, "_latency"}, seen ? lat : -1, exp_lat);
        chk({tag, "_busy_calc"}, busy_bad, 0);
        chk({tag, "_busy_done"}, mdif.MD_Busy, 0);
        chk({tag, "_result"}, mdif.MD_Result, exp_res);
        chk({tag, "_rd"}, mdif.MD_Rd, rd);
        mdif.E_Start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, mdif.MD_Done, 0);
        chk({tag, "_hold"}, mdif.MD_Result, exp_res);
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        int cnt;
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (mdif.MD_Done) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          sel;

        // Reset state, with a request pending to prove busy is forced low
        mdif.E_Start  = 1'b1;
        mdif.E_Funct3 = 3'b000;
        mdif.E_SrcA   = 32'd5;
        mdif.E_SrcB   = 32'd6;
        mdif.E_Rd     = 5'd3;
        mdif.E_Flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", mdif.MD_Busy, 0);
        chk("rst_done", mdif.MD_Done, 0);
        chk("rst_result", mdif.MD_Result, 0);
        chk("rst_rd", mdif.MD_Rd, 0);
        mdif.E_Start = 1'b0;
        rst = 1'b0;

        // Directed vectors
        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33);
        run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33);
        run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 33);
        run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
        run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 33);
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1);
        run_op("mulhsu_neg", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 33);

        // Flush at iteration cycle 10 abandons the divide
        @(negedge clk);
        mdif.E_Start  = 1'b1;
        mdif.E_Funct3 = 3'b100;
        mdif.E_SrcA   = 32'd1000;
        mdif.E_SrcB   = 32'd7;
        mdif.E_Rd     = 5'd10;
        @(posedge clk);
        #1 mdif.E_Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        mdif.E_Flush = 1'b1;
        chk("flush_busy_calc", mdif.MD_Busy, 1);
        @(posedge clk);
        #1;
        mdif.E_Flush = 1'b0;
        chk("flush_idle_busy", mdif.MD_Busy, 0);
        chk("flush_idle_done", mdif.MD_Done, 0);
        expect_no_done("flush_no_done", 40);
        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 5'd11, 32'd12, 33);

        // Flush in IDLE blocks accept
        @(negedge clk);
        mdif.E_Start  = 1'b1;
        mdif.E_Flush  = 1'b1;
        mdif.E_Funct3 = 3'b101;
        mdif.E_SrcB   = 32'd0;
        #1 chk("idle_flush_busy", mdif.MD_Busy, 0);
        expect_no_done("idle_flush_no_done", 5);
        @(negedge clk);
        mdif.E_Start = 1'b0;
        mdif.E_Flush = 1'b0;

        // Reset at iteration cycle 15
        @(negedge clk);
        mdif.E_Start  = 1'b1;
        mdif.E_Funct3 = 3'b000;
        mdif.E_SrcA   = 32'h1234;
        mdif.E_SrcB   = 32'h5678;
        mdif.E_Rd     = 5'd12;
        @(posedge clk);
        #1 mdif.E_Start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_done", mdif.MD_Done, 0);
        chk("midrst_busy", mdif.MD_Busy, 0);
        chk("midrst_result", mdif.MD_Result, 0);
        chk("midrst_rd", mdif.MD_Rd, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_no_done("midrst_no_done", 40);

        // Random ops against the reference model, biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 5);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 300);
                default: ;
            endcase
            run_op("rand", f3, a, b, rd, ref_op(f3, a, b), exp_latency(f3, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter XLEN_LOG2, default 5, iteration-counter width; 2**XLEN_LOG2 SHALL equal DATA_WIDTH.
REQ-003 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 E_Start  input  1  execute-stage instruction is an M-extension op; request operation.
REQ-007 E_Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 E_SrcA, E_SrcB  input  DATA_WIDTH  forwarded rs1 / rs2 operands.
REQ-009 E_Rd  input  5  destination register of the request.
REQ-010 E_Flush  input  1  kill the in-flight operation (branch/jump taken).
REQ-011 MD_Busy  output  1  stall request to IF/ID/EX pipeline registers.
REQ-012 MD_Done  output  1  one-cycle pulse, MD_Result/MD_Rd valid.
REQ-013 MD_Result  output  DATA_WIDTH  operation result.
REQ-014 MD_Rd  output  5  destination register latched at accept.

Function
REQ-015 FSM states: IDLE, CALC, DONE; encoding not externally visible.
REQ-016 Accept: in IDLE with E_Start=1 and E_Flush=0, the block SHALL latch funct3, operands (sign-handled), E_Rd, clear counter, and go to CALC.
REQ-017 Special case at accept: DIV/DIVU/REM/REMU with E_SrcB=0 SHALL go directly to DONE with quotient all-ones, remainder = E_SrcA.
REQ-018 Special case at accept: DIV/REM with E_SrcA=0x80000000, E_SrcB=0xFFFFFFFF SHALL go directly to DONE with quotient 0x80000000, remainder 0.
REQ-019 CALC: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) on magnitudes; exactly DATA_WIDTH cycles, then DONE.
REQ-020 DONE: MD_Done=1 for exactly one cycle, sign correction applied, then IDLE.
REQ-021 Latency: normal op, MD_Done asserted DATA_WIDTH+1 cycles after accept edge (33 at default); special cases, 1 cycle after accept.
REQ-022 Multiply: 2*DATA_WIDTH-bit product; MUL returns low half, MULH/MULHSU/MULHU return high half with signed×signed, signed×unsigned, unsigned×unsigned interpretation.
REQ-023 Divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-024 MD_Busy = (IDLE and E_Start and not E_Flush) or CALC; deasserted in DONE so the pipeline advances on the MD_Done cycle.
REQ-025 E_Start while in CALC or DONE SHALL be ignored (no re-accept, no operand change).
REQ-026 E_Flush in CALC or DONE SHALL return the FSM to IDLE on the next edge with no MD_Done pulse; E_Flush in IDLE SHALL block accept.
REQ-027 MD_Result and MD_Rd SHALL hold their last value outside DONE; consumers use them only when MD_Done=1.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, MD_Busy=0, MD_Done=0, MD_Result=0, MD_Rd=0, counter and internal datapath registers to 0.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation; no MD_Done pulse follows reset release.

Structure
REQ-030 The shared pipeline package SHALL hold the funct3 M-op encodings and the FSM state typedef/constants.
REQ-031 One sub-module, muldiv_core (iterative datapath: accumulator, shift register, counter), is natural; ex_muldiv holds the FSM, sign handling and special-case detection.

Verification
REQ-032 MUL 7 × -3 (0x00000007, 0xFFFFFFFD) -> MD_Done at cycle 33, MD_Result 0xFFFFFFEB, MD_Busy high cycles 0-32.
REQ-033 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-034 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF and REM 0x80000000 / 0xFFFFFFFF -> 0, both MD_Done one cycle after accept.
REQ-036 Start DIV, assert E_Flush at cycle 10 -> IDLE next cycle, no MD_Done; new MUL 3 × 4 accepted afterwards -> 12.
REQ-037 rst pulsed at cycle 15 of a MUL -> outputs zero immediately, no MD_Done; E_Start toggled during CALC -> result unchanged.
